flashrom_cfg_loader: RTL and testbench

//  Sequencer immediately upstream of the 128x8 Fusion flash-ROM wrapper. It drives ROM_ADDR and consumes ROM_DATA.

---
 rtl/flashrom_cfg_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_flashrom_cfg_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flashrom_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : flashrom_cfg_loader
// Purpose  : Walks a 128x8 flash-ROM image from address 0, assembles 4-byte
//            big-endian records {reg_addr[15:0], reg_data[15:0]} and issues
//            one register write per record over a strobe/ack handshake.
//            A record whose address is 16'hFFFF terminates the load.
//            Runs once after reset (AUTO_START=1) and again on each START.
// Ports    : clk       in   system clock, rising edge
//            rst_n     in   asynchronous active-low reset
//            start     in   one-cycle pulse, honoured only while idle/done
//            rom_addr  out  7-bit registered byte address to the ROM
//            rom_data  in   8-bit byte from the ROM
//            wr_addr   out  register address of the current record
//            wr_data   out  register data of the current record
//            wr_stb    out  write request, held until wr_ack
//            wr_ack    in   write accepted (sampled only while wr_stb=1)
//            busy      out  high from load start until done
//            done      out  level, set on completion, cleared by start
//            error     out  checksum failure
// Config   : FLASHROM_CFG_LOADER_CHECKSUM_EN - when defined, a 16-bit running
//            sum of written data is compared against the terminator's data
//            field; a mismatch or a missing terminator raises error.
//            When undefined, error is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module flashrom_cfg_loader #(
   parameter int ROM_LATENCY = 1,
   parameter int MAX_RECORDS = 32,
   parameter bit AUTO_START  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [6:0]  rom_addr,
   input  logic [7:0]  rom_data,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        wr_stb,
   input  logic        wr_ack,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int c_WAIT_W = (ROM_LATENCY < 1) ? 1 : $clog2(ROM_LATENCY + 1);
   localparam int c_CNT_W  = $clog2(MAX_RECORDS + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(ROM_LATENCY);
   localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(MAX_RECORDS);
   localparam logic [15:0]         c_TERM_ADDR = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_CHECK = 3'd2,
      S_WRITE = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t              r_state,    w_state_nxt;
   logic [1:0]          r_slot,     w_slot_nxt;
   logic [c_WAIT_W-1:0] r_wait,     w_wait_nxt;
   logic [c_CNT_W-1:0]  r_rec_cnt,  w_rec_cnt_nxt;
   logic [c_CNT_W-1:0]  w_cnt_inc;
   logic                r_auto,     w_auto_nxt;
   logic [6:0]          r_rom_addr, w_rom_addr_nxt;
   logic [15:0]         r_wr_addr,  w_wr_addr_nxt;
   logic [15:0]         r_wr_data,  w_wr_data_nxt;
   logic                r_wr_stb,   w_wr_stb_nxt;
   logic                r_busy,     w_busy_nxt;
   logic                r_done,     w_done_nxt;

`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
   logic [15:0]         r_sum,      w_sum_nxt;
   logic                r_err_pend, w_err_pend_nxt;
   logic                r_error,    w_error_nxt;

   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   assign rom_addr = r_rom_addr;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign wr_stb   = r_wr_stb;
   assign busy     = r_busy;
   assign done     = r_done;

   assign w_cnt_inc = r_rec_cnt + c_CNT_W'(1);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_slot     <= 2'd0;
         r_wait     <= '0;
         r_rec_cnt  <= '0;
         r_auto     <= AUTO_START;
         r_rom_addr <= 7'd0;
         r_wr_addr  <= 16'd0;
         r_wr_data  <= 16'd0;
         r_wr_stb   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
         r_sum      <= 16'd0;
         r_err_pend <= 1'b0;
         r_error    <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_slot     <= w_slot_nxt;
         r_wait     <= w_wait_nxt;
         r_rec_cnt  <= w_rec_cnt_nxt;
         r_auto     <= w_auto_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_wr_stb   <= w_wr_stb_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
         r_sum      <= w_sum_nxt;
         r_err_pend <= w_err_pend_nxt;
         r_error    <= w_error_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_slot_nxt     = r_slot;
      w_wait_nxt     = r_wait;
      w_rec_cnt_nxt  = r_rec_cnt;
      w_auto_nxt     = r_auto;
      w_rom_addr_nxt = r_rom_addr;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;
      w_wr_stb_nxt   = r_wr_stb;
      w_busy_nxt     = r_busy;
      w_done_nxt     = r_done;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
      w_sum_nxt      = r_sum;
      w_err_pend_nxt = r_err_pend;
      w_error_nxt    = r_error;
`endif

      case (r_state)
         S_IDLE: begin
            // r_auto stands in for a start pulse on the first cycle after reset
            if (start || r_auto) begin
               w_auto_nxt     = 1'b0;
               w_slot_nxt     = 2'd0;
               w_wait_nxt     = '0;
               w_rec_cnt_nxt  = '0;
               w_rom_addr_nxt = 7'd0;
               w_busy_nxt     = 1'b1;
               w_done_nxt     = 1'b0;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
               w_sum_nxt      = 16'd0;
               w_err_pend_nxt = 1'b0;
               w_error_nxt    = 1'b0;
`endif
               w_state_nxt    = S_FETCH;
            end
         end

         S_FETCH: begin
            // r_wait counts edges since rom_addr changed; the byte is valid
            // once the ROM's registered read has had ROM_LATENCY edges.
            if (r_wait == c_WAIT_LAST) begin
               w_wait_nxt = '0;
               case (r_slot)
                  2'd0: w_wr_addr_nxt[15:8] = rom_data;
                  2'd1: w_wr_addr_nxt[7:0]  = rom_data;
                  2'd2: w_wr_data_nxt[15:8] = rom_data;
                  2'd3: w_wr_data_nxt[7:0]  = rom_data;
                  default: ;
               endcase
               if (r_slot == 2'd3) begin
                  // The address step past the last byte of a record is
                  // deferred to the ack, so a terminator leaves rom_addr on
                  // its final byte and the last record wraps to 0.
                  w_slot_nxt  = 2'd0;
                  w_state_nxt = S_CHECK;
               end else begin
                  w_slot_nxt     = r_slot + 2'd1;
                  w_rom_addr_nxt = r_rom_addr + 7'd1;
               end
            end else begin
               w_wait_nxt = r_wait + c_WAIT_W'(1);
            end
         end

         S_CHECK: begin
            if (r_wr_addr == c_TERM_ADDR) begin
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
               w_err_pend_nxt = (r_wr_data != r_sum);
`endif
               w_state_nxt = S_FIN;
            end else begin
               w_wr_stb_nxt = 1'b1;
               w_state_nxt  = S_WRITE;
            end
         end

         S_WRITE: begin
            if (r_wr_stb && wr_ack) begin
               w_wr_stb_nxt   = 1'b0;
               w_rec_cnt_nxt  = w_cnt_inc;
               w_rom_addr_nxt = r_rom_addr + 7'd1;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
               w_sum_nxt      = r_sum + r_wr_data;
`endif
               if (w_cnt_inc == c_CNT_MAX) begin
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
                  // Running out of records without a terminator is an error
                  w_err_pend_nxt = 1'b1;
`endif
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end
         end

         S_FIN: begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
            w_error_nxt = r_err_pend;
`endif
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_flashrom_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_flashrom_cfg_loader
// Purpose  : Self-checking bench for flashrom_cfg_loader. Holds a registered
//            128x8 ROM model, an ack responder with programmable delay, and
//            a record-level reference model that predicts the write list,
//            final rom_addr and error flag from the ROM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flashrom_cfg_loader;

   localparam int c_MAX = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  rom_addr;
   logic [7:0]  rom_data = 8'd0;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_stb;
   logic        wr_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        error;

   flashrom_cfg_loader #(
      .ROM_LATENCY (1),
      .MAX_RECORDS (c_MAX),
      .AUTO_START  (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_stb   (wr_stb),
      .wr_ack   (wr_ack),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  rom_mem [128];
   logic [31:0] img_q [$];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   int          ack_delay = 0;
   int          ack_cnt   = 0;
   logic [31:0] held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered ROM: data follows the address by one edge
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // Ack responder and write logger. An ack raised here is accepted at the
   // following rising edge, so the write is logged when it is raised.
   always @(negedge clk) begin
      if (wr_stb) begin
         if (ack_cnt > 0) check("stb_hold", {wr_addr, wr_data}, held);
         else held = {wr_addr, wr_data};
         if (ack_cnt >= ack_delay) begin
            wr_ack = 1'b1;
            got_q.push_back({wr_addr, wr_data});
         end else begin
            wr_ack = 1'b0;
         end
         ack_cnt++;
      end else begin
         wr_ack  = 1'b0;
         ack_cnt = 0;
      end
   end

   // Lay records into the ROM; unused bytes get random filler
   task automatic write_rom();
      for (int i = 0; i < 128; i++) rom_mem[i] = 8'($urandom);
      for (int r = 0; r < img_q.size(); r++) begin
         rom_mem[4*r]   = img_q[r][31:24];
         rom_mem[4*r+1] = img_q[r][23:16];
         rom_mem[4*r+2] = img_q[r][15:8];
         rom_mem[4*r+3] = img_q[r][7:0];
      end
   endtask

   task automatic build_image(input int kind);
      img_q.delete();
      case (kind)
         0: img_q = '{32'h0010_ABCD, 32'h0011_1234, 32'hFFFF_BE01};
         1: img_q = '{32'h0001_0005, 32'h0002_0007, 32'hFFFF_000C};
         2: img_q = '{32'h0001_0005, 32'h0002_0007, 32'hFFFF_000D};
         3: for (int i = 0; i < c_MAX; i++)
               img_q.push_back({16'(16'h0100 + i), 16'(i * 3 + 1)});
         default: img_q = '{32'hFFFF_0000};
      endcase
      write_rom();
   endtask

   // Record-level reference: read the ROM as a list of records, stop at the
   // first terminator or after c_MAX records.
   task automatic model_run(output int nw, output int faddr, output logic err);
      logic [15:0] sum;
      logic [15:0] a;
      logic [15:0] d;
      bit          found;
      sum   = 16'd0;
      found = 1'b0;
      nw    = 0;
      faddr = 0;
      err   = 1'b1;
      exp_q.delete();
      for (int r = 0; r < c_MAX && !found; r++) begin
         a = {rom_mem[4*r], rom_mem[4*r+1]};
         d = {rom_mem[4*r+2], rom_mem[4*r+3]};
         if (a == 16'hFFFF) begin
            found = 1'b1;
            faddr = 4*r + 3;
            err   = (d != sum);
         end else begin
            exp_q.push_back({a, d});
            sum = sum + d;
            nw++;
         end
      end
      if (!found) faddr = (4 * c_MAX) % 128;
`ifndef FLASHROM_CFG_LOADER_CHECKSUM_EN
      err = 1'b0;
`endif
   endtask

   task automatic wait_done(input bit mid_start);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         start = (mid_start && k == 3);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!ok) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_done_clr", 32'(done), 32'd0);
   endtask

   task automatic compare_writes(input int nw);
      check("wr_count", 32'(got_q.size()), 32'(nw));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check("wr_rec", got_q[i], exp_q[i]);
   endtask

   task automatic check_end(input int faddr, input logic err);
      check("end_done", 32'(done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_rom_addr", 32'(rom_addr), 32'(faddr));
      check("end_error", 32'(error), 32'(err));
   endtask

   typedef struct {
      int   img;
      int   dly;
      int   exp_writes;
      int   exp_addr;
      logic exp_err_cs;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int   nw;
      int   faddr;
      logic err;
      logic exp_err;
      bit   ok;

      vecs[0] = '{img: 0, dly: 0,  exp_writes: 2,  exp_addr: 11, exp_err_cs: 1'b0};
      vecs[1] = '{img: 1, dly: 2,  exp_writes: 2,  exp_addr: 11, exp_err_cs: 1'b0};
      vecs[2] = '{img: 2, dly: 1,  exp_writes: 2,  exp_addr: 11, exp_err_cs: 1'b1};
      vecs[3] = '{img: 3, dly: 0,  exp_writes: 32, exp_addr: 0,  exp_err_cs: 1'b1};
      vecs[4] = '{img: 4, dly: 3,  exp_writes: 0,  exp_addr: 3,  exp_err_cs: 1'b0};
      vecs[5] = '{img: 0, dly: 10, exp_writes: 2,  exp_addr: 11, exp_err_cs: 1'b0};

      // ---- reset values, then the automatic load after release ----
      build_image(0);
      ack_delay = 0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {rom_addr, wr_addr, wr_data, wr_stb, busy, done, error},
            32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("auto_busy", 32'(busy), 32'd1);
      wait_done(1'b0);
      check("auto_wr_count", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         check("auto_wr0", got_q[0], 32'h0010_ABCD);
         check("auto_wr1", got_q[1], 32'h0011_1234);
      end
      check_end(11, 1'b0);
      repeat (4) @(negedge clk);
      check("done_holds", 32'(done), 32'd1);

      // ---- table vectors ----
      foreach (vecs[v]) begin
         build_image(vecs[v].img);
         model_run(nw, faddr, err);
         got_q.delete();
         ack_delay = vecs[v].dly;
`ifdef FLASHROM_CFG_LOADER_CHECKSUM_EN
         exp_err = vecs[v].exp_err_cs;
`else
         exp_err = 1'b0;
`endif
         pulse_start();
         wait_done(vecs[v].img == 3);
         check("vec_count", 32'(got_q.size()), 32'(vecs[v].exp_writes));
         compare_writes(nw);
         check_end(vecs[v].exp_addr, exp_err);
      end

      // ---- reset while a write is pending ----
      build_image(3);
      model_run(nw, faddr, err);
      got_q.delete();
      ack_delay = 50;
      pulse_start();
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (wr_stb) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("stb_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_stb", 32'(wr_stb), 32'd0);
      check("rst_async_outs", {rom_addr, wr_addr, wr_data, wr_stb, busy, done, error},
            32'd0);
      ack_delay = 0;
      @(negedge clk);
      got_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_addr", 32'(rom_addr), 32'd0);
      wait_done(1'b0);
      compare_writes(nw);
      check_end(faddr, err);

      // ---- random images against the reference model ----
      for (int t = 0; t < 20; t++) begin
         int          nrec;
         logic [15:0] sum;
         logic [15:0] a;
         logic [15:0] d;
         nrec = $urandom_range(0, 34);
         sum  = 16'd0;
         img_q.delete();
         for (int r = 0; r < nrec && r < c_MAX; r++) begin
            a = 16'($urandom);
            if (a == 16'hFFFF) a = 16'h0000;
            d = 16'($urandom);
            img_q.push_back({a, d});
            sum = sum + d;
         end
         if (nrec < c_MAX)
            img_q.push_back({16'hFFFF, ($urandom_range(0, 1) == 1) ? sum : 16'($urandom)});
         write_rom();
         model_run(nw, faddr, err);
         got_q.delete();
         ack_delay = $urandom_range(0, 3);
         pulse_start();
         wait_done(1'b1);
         compare_writes(nw);
         check_end(faddr, err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
